// File: rtl/imem_responder.sv
// Memory-side responder for the tagged icache bus: accepts loads/stores, hands out
// nonzero tags, and returns snapshotted load data a fixed number of cycles later.
module imem_responder #(
  parameter int DEPTH           = 1024,
  parameter int LATENCY         = 8,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] proc2mem_addr,
  input  logic [63:0] proc2mem_data,
  input  logic [1:0]  proc2mem_command,
  output logic [3:0]  mem2proc_response,
  output logic [63:0] mem2proc_data,
  output logic [3:0]  mem2proc_tag
);

  localparam logic [1:0] BUS_NONE  = 2'd0;
  localparam logic [1:0] BUS_LOAD  = 2'd1;
  localparam logic [1:0] BUS_STORE = 2'd2;

  localparam int AW = $clog2(LATENCY + 1);
  localparam int MW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam bit BYPASS = (LATENCY == 1);
  // Head leaves storage one cycle early so the registered output lands on T+LATENCY.
  localparam logic [AW-1:0] POP_AGE  = AW'((LATENCY > 1) ? LATENCY - 2 : 0);
  localparam logic [CW-1:0] FULL_CNT = CW'(MAX_OUTSTANDING);
  localparam logic [PW-1:0] LAST_PTR = PW'(MAX_OUTSTANDING - 1);

  logic [63:0]   mem_r     [DEPTH];
  logic [3:0]    tag_q_r   [MAX_OUTSTANDING];
  logic [63:0]   data_q_r  [MAX_OUTSTANDING];
  logic [AW-1:0] age_q_r   [MAX_OUTSTANDING];
  logic [MAX_OUTSTANDING-1:0] valid_q_r;
  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic [3:0]    tag_cnt_r;
  logic [3:0]    out_tag_r;
  logic [63:0]   out_data_r;

  logic [28:0]   word_idx_s;
  logic [MW-1:0] mem_idx_s;
  logic          in_range_s;
  logic          full_s;
  logic          load_acc_s;
  logic          store_acc_s;
  logic [3:0]    tag_next_s;
  logic          push_s;
  logic          pop_s;
  logic          done_valid_s;
  logic [3:0]    done_tag_s;
  logic [63:0]   done_data_s;
  logic          addr_unused_s;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
    if (ptr == LAST_PTR) begin
      ptr_inc = {PW{1'b0}};
    end else begin
      ptr_inc = ptr + PW'(1'b1);
    end
  endfunction

  assign addr_unused_s = ^proc2mem_addr[2:0];

  // Command decode and acceptance; occupancy counts the load completing this cycle.
  always_comb begin
    word_idx_s  = proc2mem_addr[31:3];
    mem_idx_s   = word_idx_s[MW-1:0];
    in_range_s  = ({3'b000, word_idx_s} < 32'(DEPTH));
    full_s      = (count_r == FULL_CNT);
    load_acc_s  = 1'b0;
    store_acc_s = 1'b0;
    tag_next_s  = (tag_cnt_r == 4'd15) ? 4'd1 : tag_cnt_r + 4'd1;
    if (reset) begin
      load_acc_s  = 1'b0;
      store_acc_s = 1'b0;
    end else begin
      case (proc2mem_command)
        BUS_LOAD:  load_acc_s  = in_range_s && !full_s;
        BUS_STORE: store_acc_s = in_range_s;
        BUS_NONE:  load_acc_s  = 1'b0;
        default:   load_acc_s  = 1'b0;
      endcase
    end
    if (load_acc_s || store_acc_s) begin
      mem2proc_response = tag_cnt_r;
    end else begin
      mem2proc_response = 4'd0;
    end
  end

  // Selects what completes next: the FIFO head, or the fresh load when latency is one.
  always_comb begin
    push_s       = 1'b0;
    pop_s        = 1'b0;
    done_valid_s = 1'b0;
    done_tag_s   = 4'd0;
    done_data_s  = 64'd0;
    if (BYPASS) begin
      done_valid_s = load_acc_s;
      done_tag_s   = tag_cnt_r;
      done_data_s  = mem_r[mem_idx_s];
    end else begin
      push_s       = load_acc_s;
      pop_s        = valid_q_r[rd_ptr_r] && (age_q_r[rd_ptr_r] == POP_AGE);
      done_valid_s = pop_s;
      done_tag_s   = tag_q_r[rd_ptr_r];
      done_data_s  = data_q_r[rd_ptr_r];
    end
  end

  // Control state: tag counter, occupancy, FIFO pointers and the registered completion.
  always_ff @(posedge clock) begin
    if (reset) begin
      tag_cnt_r  <= 4'd1;
      count_r    <= {CW{1'b0}};
      wr_ptr_r   <= {PW{1'b0}};
      rd_ptr_r   <= {PW{1'b0}};
      valid_q_r  <= {MAX_OUTSTANDING{1'b0}};
      out_tag_r  <= 4'd0;
      out_data_r <= 64'd0;
    end else begin
      if (load_acc_s || store_acc_s) begin
        tag_cnt_r <= tag_next_s;
      end
      count_r <= count_r + CW'(load_acc_s) - CW'(out_tag_r != 4'd0);
      if (push_s) begin
        valid_q_r[wr_ptr_r] <= 1'b1;
        wr_ptr_r            <= ptr_inc(wr_ptr_r);
      end
      if (pop_s) begin
        valid_q_r[rd_ptr_r] <= 1'b0;
        rd_ptr_r            <= ptr_inc(rd_ptr_r);
      end
      if (done_valid_s) begin
        out_tag_r  <= done_tag_s;
        out_data_r <= done_data_s;
      end else begin
        out_tag_r  <= 4'd0;
        out_data_r <= 64'd0;
      end
    end
  end

  // Backing store write; contents deliberately survive reset.
  always_ff @(posedge clock) begin
    if (store_acc_s) begin
      mem_r[mem_idx_s] <= proc2mem_data;
    end
  end

  // In-flight entries: ages advance in lockstep, a push snapshots tag and data.
  always_ff @(posedge clock) begin
    for (int i = 0; i < MAX_OUTSTANDING; i++) begin
      age_q_r[i] <= age_q_r[i] + AW'(1'b1);
    end
    if (push_s) begin
      age_q_r[wr_ptr_r]  <= {AW{1'b0}};
      tag_q_r[wr_ptr_r]  <= tag_cnt_r;
      data_q_r[wr_ptr_r] <= mem_r[mem_idx_s];
    end
  end

  assign mem2proc_tag  = out_tag_r;
  assign mem2proc_data = out_data_r;

endmodule

// File: tb/tb_imem_responder.sv
// Randomised self-checking bench for imem_responder against a timestamped
// scoreboard model of the tagged memory bus.
module tb_imem_responder;

  localparam int DEPTH = 1024;
  localparam int LAT   = 8;
  localparam int MAXO  = 4;
  localparam logic [1:0] C_NONE  = 2'd0;
  localparam logic [1:0] C_LOAD  = 2'd1;
  localparam logic [1:0] C_STORE = 2'd2;

  logic        clock;
  logic        reset;
  logic [31:0] proc2mem_addr;
  logic [63:0] proc2mem_data;
  logic [1:0]  proc2mem_command;
  logic [3:0]  mem2proc_response;
  logic [63:0] mem2proc_data;
  logic [3:0]  mem2proc_tag;

  imem_responder #(.DEPTH(DEPTH), .LATENCY(LAT), .MAX_OUTSTANDING(MAXO)) dut (
    .clock(clock), .reset(reset),
    .proc2mem_addr(proc2mem_addr), .proc2mem_data(proc2mem_data),
    .proc2mem_command(proc2mem_command),
    .mem2proc_response(mem2proc_response), .mem2proc_data(mem2proc_data),
    .mem2proc_tag(mem2proc_tag)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    int          due;
    logic [3:0]  tag;
    logic [63:0] data;
    bit          known;
  } pend_t;

  pend_t       pend[$];
  logic [63:0] m_mem [int];
  logic [3:0]  m_tag;
  int          cyc;
  int          n_pass;
  int          n_total;

  logic [3:0]  obs_resp, obs_tag, exp_resp, exp_tag;
  logic [63:0] obs_data, exp_data;
  bit          exp_known;

  // One bus cycle: drive, sample, predict from the model, then advance the model.
  task automatic drive_cycle(input logic [1:0] cmd, input logic [31:0] addr,
                             input logic [63:0] data, input bit rst);
    int word;
    int inflight;
    reset = rst;
    proc2mem_command = cmd;
    proc2mem_addr = addr;
    proc2mem_data = data;
    #1;
    obs_resp = mem2proc_response;
    obs_tag  = mem2proc_tag;
    obs_data = mem2proc_data;
    exp_tag = 4'd0;
    exp_data = 64'd0;
    exp_known = 1'b1;
    inflight = 0;
    foreach (pend[i]) begin
      if (pend[i].due == cyc) begin
        exp_tag = pend[i].tag;
        exp_data = pend[i].data;
        exp_known = pend[i].known;
      end
      if (pend[i].due >= cyc) inflight++;
    end
    word = int'(addr[31:3]);
    exp_resp = 4'd0;
    if (!rst && word < DEPTH && (cmd == C_STORE || (cmd == C_LOAD && inflight < MAXO)))
      exp_resp = m_tag;
    if (rst) begin
      pend.delete();
      m_tag = 4'd1;
    end else if (exp_resp != 4'd0) begin
      if (cmd == C_STORE) m_mem[word] = data;
      else pend.push_back('{cyc + LAT, m_tag,
                            m_mem.exists(word) ? m_mem[word] : 64'd0, m_mem.exists(word)});
      m_tag = (m_tag == 4'd15) ? 4'd1 : m_tag + 4'd1;
    end
    while (pend.size() > 0 && pend[0].due <= cyc) void'(pend.pop_front());
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      drive_cycle(C_LOAD, 32'h0000_0040, 64'd0, 1'b1);
      n_total++;
      if (obs_resp !== 4'd0 || obs_tag !== 4'd0 || obs_data !== 64'd0)
        $display("FAIL reset resp=%0d tag=%0d data=%h, want 0/0/0", obs_resp, obs_tag, obs_data);
      else n_pass++;
    end
  endtask

  task automatic test_store_load();
    drive_cycle(C_STORE, 32'h0000_0040, 64'hDEADBEEF_01234567, 1'b0);
    n_total++;
    if (obs_resp !== 4'd1) $display("FAIL store_resp got %0d want 1", obs_resp);
    else n_pass++;
    drive_cycle(C_LOAD, 32'h0000_0044, 64'd0, 1'b0);
    n_total++;
    if (obs_resp !== 4'd2) $display("FAIL load_resp got %0d want 2", obs_resp);
    else n_pass++;
    for (int k = 0; k < 10; k++) begin
      drive_cycle(C_NONE, 32'd0, 64'd0, 1'b0);
      n_total++;
      if ((k == 7) ? (obs_tag !== 4'd2 || obs_data !== 64'hDEADBEEF_01234567)
                   : (obs_tag !== 4'd0 || obs_data !== 64'd0))
        $display("FAIL load_return k=%0d tag=%0d data=%h", k, obs_tag, obs_data);
      else n_pass++;
    end
  endtask

  task automatic test_full();
    logic [3:0] first_tag;
    first_tag = 4'd0;
    for (int i = 0; i < 5; i++) begin
      drive_cycle(C_LOAD, 32'h0000_0040 + 32'(i * 8), 64'd0, 1'b0);
      if (i == 0) first_tag = obs_resp;
      n_total++;
      if ((i < 4 && obs_resp == 4'd0) || (i == 4 && obs_resp !== 4'd0) || obs_resp !== exp_resp)
        $display("FAIL full_issue i=%0d resp=%0d model=%0d", i, obs_resp, exp_resp);
      else n_pass++;
    end
    for (int i = 0; i < 3; i++) drive_cycle(C_NONE, 32'd0, 64'd0, 1'b0);
    drive_cycle(C_LOAD, 32'h0000_0060, 64'd0, 1'b0);
    n_total++;
    if (obs_resp !== 4'd0 || obs_tag !== first_tag)
      $display("FAIL full_retry resp=%0d tag=%0d want 0/%0d", obs_resp, obs_tag, first_tag);
    else n_pass++;
    drive_cycle(C_LOAD, 32'h0000_0060, 64'd0, 1'b0);
    n_total++;
    if (obs_resp === 4'd0 || obs_resp !== exp_resp)
      $display("FAIL full_next resp=%0d model=%0d", obs_resp, exp_resp);
    else n_pass++;
    for (int i = 0; i < 12; i++) begin
      drive_cycle(C_NONE, 32'd0, 64'd0, 1'b0);
      n_total++;
      if (obs_tag !== exp_tag || (exp_known && obs_data !== exp_data))
        $display("FAIL full_drain tag=%0d/%0d data=%h/%h", obs_tag, exp_tag, obs_data, exp_data);
      else n_pass++;
    end
  endtask

  task automatic test_snapshot();
    drive_cycle(C_STORE, 32'h0000_0080, 64'h1111_2222_3333_4444, 1'b0);
    drive_cycle(C_LOAD, 32'h0000_0080, 64'd0, 1'b0);
    drive_cycle(C_STORE, 32'h0000_0080, 64'h5555_6666_7777_8888, 1'b0);
    for (int k = 0; k < 9; k++) begin
      drive_cycle(C_NONE, 32'd0, 64'd0, 1'b0);
      if (k == 6) begin
        n_total++;
        if (obs_tag === 4'd0 || obs_data !== 64'h1111_2222_3333_4444)
          $display("FAIL snapshot tag=%0d data=%h want old data", obs_tag, obs_data);
        else n_pass++;
      end
    end
  endtask

  task automatic test_tag_wrap();
    drive_cycle(C_NONE, 32'd0, 64'd0, 1'b1);
    for (int i = 0; i < 16; i++) begin
      drive_cycle(C_STORE, {20'd0, 7'($urandom_range(0, 31)), 5'd0}, {$urandom, $urandom}, 1'b0);
      n_total++;
      if (obs_resp !== 4'((i % 15) + 1))
        $display("FAIL tag_wrap i=%0d got %0d want %0d", i, obs_resp, (i % 15) + 1);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    drive_cycle(C_LOAD, 32'h0000_0040, 64'd0, 1'b0);
    drive_cycle(C_NONE, 32'd0, 64'd0, 1'b0);
    drive_cycle(C_NONE, 32'd0, 64'd0, 1'b0);
    drive_cycle(C_STORE, 32'h0000_0040, 64'hAAAA_0000_BBBB_0000, 1'b1);
    n_total++;
    if (obs_resp !== 4'd0) $display("FAIL reset_mid_resp got %0d want 0", obs_resp);
    else n_pass++;
    for (int k = 0; k < 10; k++) begin
      drive_cycle(C_NONE, 32'd0, 64'd0, 1'b0);
      n_total++;
      if (obs_tag !== 4'd0) $display("FAIL reset_mid_drop k=%0d tag=%0d want 0", k, obs_tag);
      else n_pass++;
    end
    drive_cycle(C_STORE, 32'h0000_0048, 64'h0123_4567_89AB_CDEF, 1'b0);
    n_total++;
    if (obs_resp !== 4'd1) $display("FAIL reset_mid_first got %0d want 1", obs_resp);
    else n_pass++;
  endtask

  task automatic test_out_of_range();
    drive_cycle(C_LOAD, 32'(DEPTH) << 3, 64'd0, 1'b0);
    n_total++;
    if (obs_resp !== 4'd0) $display("FAIL oor_resp got %0d want 0", obs_resp);
    else n_pass++;
    for (int k = 0; k < 10; k++) begin
      drive_cycle(C_NONE, 32'd0, 64'd0, 1'b0);
      n_total++;
      if (obs_tag !== 4'd0) $display("FAIL oor_completion k=%0d tag=%0d", k, obs_tag);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    logic [1:0]  cmd;
    logic [31:0] addr;
    for (int i = 0; i < 300; i++) begin
      cmd = 2'($urandom_range(0, 2));
      if ($urandom_range(0, 9) == 0) addr = (32'(DEPTH) + 32'($urandom_range(0, 7))) << 3;
      else addr = {20'd0, 7'($urandom_range(0, 31)), 5'($urandom)};
      drive_cycle(cmd, addr, {$urandom, $urandom}, ($urandom_range(0, 99) == 0));
      n_total++;
      if (obs_resp !== exp_resp || obs_tag !== exp_tag || (exp_known && obs_data !== exp_data))
        $display("FAIL random cyc=%0d resp=%0d/%0d tag=%0d/%0d data=%h/%h",
                 cyc, obs_resp, exp_resp, obs_tag, exp_tag, obs_data, exp_data);
      else n_pass++;
    end
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    reset = 1'b1;
    proc2mem_command = C_NONE;
    proc2mem_addr = 32'd0;
    proc2mem_data = 64'd0;
    @(posedge clock);
    #1;
    cyc = 0;
    m_tag = 4'd1;
    test_reset();
    test_store_load();
    test_full();
    test_snapshot();
    test_tag_wrap();
    test_reset_mid();
    test_out_of_range();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
